// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with its own 256x8 program memory.
//
// The block is loaded with a program through the prog_* port while in LOAD.
// It then fetches one word per cycle in RUN and stops in HALT when the word
// at pc equals HALT_OPCODE.
//
// Parameters
//   RESET_PC       PC value loaded on reset and on re-entry to LOAD
//   HALT_OPCODE    instruction value that ends fetching
//
// Ports
//   clk              in   1  rising-edge clock
//   rst              in   1  synchronous, active-high reset
//   start            in   1  LOAD -> RUN, or HALT -> LOAD
//   prog_we          in   1  program-load write enable (LOAD only)
//   prog_addr        in   8  program-load write address
//   prog_data        in   8  program-load write data
//   stall            in   1  hold pc (shared with IF/ID stall)
//   branch_taken     in   1  redirect pc to branch_target
//   branch_target    in   8  redirect destination
//   if_instruction   out  8  mem[pc] while fetching, else 0
//   if_pc            out  8  pc register
//   if_valid         out  1  state is RUN
//   flush            out  1  squash IF/ID this cycle (branch in RUN)
//   halted           out  1  state is HALT
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic [7:0] if_instruction,
    output logic [7:0] if_pc,
    output logic       if_valid,
    output logic       flush,
    output logic       halted
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_pc;
    logic [7:0] w_pc_nxt;
    logic [7:0] r_mem [0:255];
    logic [7:0] w_mem_rd;
    logic       w_run;

    // Asynchronous read at the current pc.
    assign w_mem_rd = r_mem[r_pc];
    assign w_run    = (r_state == S_RUN);

    // Program memory has no reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (!rst && prog_we && (r_state == S_LOAD)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_LOAD: begin
                w_pc_nxt = RESET_PC;
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A branch beats a stall; a stall masks a halt opcode so
                // the halt is only taken on an unstalled cycle.
                if (branch_taken) begin
                    w_pc_nxt = branch_target;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_mem_rd == HALT_OPCODE) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_pc_nxt = r_pc + 8'd1;
                end
            end
            S_HALT: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_pc_nxt    = RESET_PC;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
                w_pc_nxt    = RESET_PC;
            end
        endcase
    end

    assign if_valid       = w_run;
    assign if_instruction = w_run ? w_mem_rd : 8'h00;
    assign if_pc          = r_pc;
    assign flush          = branch_taken & w_run;
    assign halted         = (r_state == S_HALT);

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] if_instruction;
    logic [7:0] if_pc;
    logic       if_valid;
    logic       flush;
    logic       halted;

    int total = 0;
    int bad   = 0;

    if_stage #(.RESET_PC(8'h00), .HALT_OPCODE(8'hFF)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .flush          (flush),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // One step: inputs driven for a cycle, plus the outputs expected during
    // that cycle (before the edge that consumes the inputs).
    typedef struct {
        logic       rst;
        logic       start;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       stall;
        logic       br;
        logic [7:0] tgt;
        logic [7:0] e_pc;
        logic [7:0] e_ins;
        logic       e_v;
        logic       e_f;
        logic       e_h;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic s, input logic w,
                       input logic [7:0] a, input logic [7:0] d,
                       input logic st, input logic b, input logic [7:0] t,
                       input logic [7:0] epc, input logic [7:0] eins,
                       input logic ev, input logic ef, input logic eh);
        vec_t x;
        x.rst = r;  x.start = s; x.we = w; x.addr = a; x.data = d;
        x.stall = st; x.br = b; x.tgt = t;
        x.e_pc = epc; x.e_ins = eins; x.e_v = ev; x.e_f = ef; x.e_h = eh;
        vq.push_back(x);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [7:0] epc,
                           input logic [7:0] eins, input logic ev,
                           input logic ef, input logic eh);
        chk("if_pc",          idx, if_pc,                epc);
        chk("if_instruction", idx, if_instruction,       eins);
        chk("if_valid",       idx, {7'd0, if_valid},     {7'd0, ev});
        chk("flush",          idx, {7'd0, flush},        {7'd0, ef});
        chk("halted",         idx, {7'd0, halted},       {7'd0, eh});
    endtask

    task automatic drive(input logic r, input logic s, input logic w,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic st, input logic b, input logic [7:0] t);
        rst = r; start = s; prog_we = w; prog_addr = a; prog_data = d;
        stall = st; branch_taken = b; branch_target = t;
    endtask

    initial begin
        //   rst st we addr  data  stl br tgt    pc    ins   v  f  h
        // Load program; branch request in LOAD must not flush or move pc.
        add(0, 0, 1, 8'h00, 8'h10, 0, 1, 8'h55, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 8'h01, 8'h11, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 8'h02, 8'h12, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        // Last write and start on the same edge.
        add(0, 1, 1, 8'h03, 8'hFF, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        // Sequential fetch into the halt word.
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h10, 1, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 8'h11, 1, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h02, 8'h12, 1, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h03, 8'hFF, 1, 0, 0);
        // HALT ignores branch and stall; flush stays low.
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h55, 8'h03, 8'h00, 0, 0, 1);
        // prog_we ignored in HALT; start returns to LOAD.
        add(0, 1, 1, 8'h00, 8'h77, 0, 0, 8'h00, 8'h03, 8'h00, 0, 0, 1);
        add(0, 0, 1, 8'h80, 8'h33, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 1, 8'hFF, 8'h44, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 1, 1, 8'h42, 8'h99, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        // mem[0] still 0x10 (HALT write dropped); stall 2 cycles at pc=1.
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h10, 1, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h01, 8'h11, 1, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h01, 8'h11, 1, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h01, 8'h11, 1, 0, 0);
        // Branch over stall to 0x80, then to 0xFF, which wraps to 0x00.
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h80, 8'h02, 8'h12, 1, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'hFF, 8'h80, 8'h33, 1, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'hFF, 8'h44, 1, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h42, 8'h00, 8'h10, 1, 1, 0);
        // Reset mid-run at pc=0x42, then restart: memory preserved.
        add(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h42, 8'h99, 1, 0, 0);
        add(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h42, 8'h00, 8'h10, 1, 1, 0);
        // Branch onto a halt word; stall holds off the halt one cycle.
        add(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h03, 8'h42, 8'h99, 1, 1, 0);
        add(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h03, 8'hFF, 1, 0, 0);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h03, 8'hFF, 1, 0, 0);
        // HALT, start -> LOAD with pc=RESET_PC.
        add(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h03, 8'h00, 0, 0, 1);
        add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

        drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
        #1;
        chk_all(-1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].start, vq[i].we, vq[i].addr, vq[i].data,
                  vq[i].stall, vq[i].br, vq[i].tgt);
            #1;
            chk_all(i, vq[i].e_pc, vq[i].e_ins, vq[i].e_v, vq[i].e_f, vq[i].e_h);
        end

        // Reset wins over start in LOAD.
        @(negedge clk);
        drive(1, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00);
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
        #1;
        chk_all(100, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Free-running fetch from 0 reaches the halt word at 3 and stays.
        @(negedge clk);
        drive(0, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00);
        @(negedge clk);
        drive(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
        #1;
        chk_all(101, 8'h00, 8'h10, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        chk_all(102, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk_all(103, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset and on re-entry to LOAD.
REQ-002 The block SHALL have parameter HALT_OPCODE, default 8'hFF, meaning the instruction value that ends fetching.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: leave LOAD and begin fetching; from HALT, return to LOAD.
REQ-006 The block SHALL have ports prog_we, prog_addr and prog_data: input, 1/8/8 bits; program-load write port into instruction memory.
REQ-007 The block SHALL have port stall, input, 1 bit: hold PC; driven by the same hazard logic that stalls IF/ID.
REQ-008 The block SHALL have ports branch_taken and branch_target: input, 1/8 bits; PC redirect request and destination.
REQ-009 The block SHALL have port if_instruction, output, 8 bits: fetched instruction, fed to the IF/ID register.
REQ-010 The block SHALL have ports if_pc and if_valid: output, 8/1 bits; current PC, and fetched word is meaningful.
REQ-011 The block SHALL have port flush, output, 1 bit: squash the IF/ID register this cycle.
REQ-012 The block SHALL have port halted, output, 1 bit: fetch has stopped on HALT_OPCODE.

Function
REQ-013 Instruction memory SHALL be 256x8: synchronous write, asynchronous read at pc.
REQ-014 State machine SHALL have states LOAD, RUN and HALT.
REQ-015 In LOAD: prog_we=1 writes prog_data to mem[prog_addr] at the edge; pc held at RESET_PC; start=1 moves to RUN next edge.
REQ-016 prog_we and start asserted together in LOAD SHALL perform the write and the transition on the same edge.
REQ-017 In RUN, PC update priority SHALL be:
  - branch_taken: pc<=branch_target
  - stall: pc held
  - mem[pc]==HALT_OPCODE: go HALT, pc held
  - otherwise: pc<=pc+1
REQ-018 PC increment SHALL be modulo 256 (8'hFF+1 -> 8'h00).
REQ-019 A halt opcode at pc while stall=1 SHALL NOT cause a halt until stall deasserts.
REQ-020 A taken branch to a location holding HALT_OPCODE SHALL halt on the following unstalled cycle.
REQ-021 prog_we SHALL be ignored outside LOAD.
REQ-022 flush SHALL equal branch_taken AND state==RUN, combinationally, with zero latency.
REQ-023 if_valid SHALL equal (state==RUN).
REQ-024 if_instruction SHALL be mem[pc] when if_valid=1, else 8'h00.
REQ-025 if_pc SHALL always equal the pc register.
REQ-026 halted SHALL equal (state==HALT).
REQ-027 In HALT: branch_taken and stall ignored, flush=0; start=1 moves to LOAD with pc<=RESET_PC.

Reset
REQ-028 rst=1 at a clock edge SHALL force state LOAD and pc=RESET_PC, overriding all other inputs in any state.
REQ-029 While in reset or LOAD, outputs SHALL be if_instruction=0, if_valid=0, flush=0, halted=0, if_pc=RESET_PC.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-031 Load and sequential fetch: load 0x10,0x11,0x12,0xFF at addresses 0-3, then start -> if_pc 0,1,2,3 on successive cycles with matching if_instruction; halted=1 from the next cycle and pc stays 3.
REQ-032 Stall: stall high for 2 cycles at pc=1 -> if_pc stays 1 for 3 cycles total, then advances to 2.
REQ-033 Branch over stall: branch_taken=1 with target 0x80 and stall=1 in the same cycle -> flush=1 that cycle, if_pc=0x80 next cycle.
REQ-034 Wrap-around: branch to 0xFF holding a non-halt word -> next if_pc=0x00.
REQ-035 Reset mid-run: rst at pc=0x42 -> next cycle state LOAD, if_pc=0x00, if_valid=0; memory contents still readable after restart.
REQ-036 Halt under stall and restart: HALT_OPCODE at pc with stall=1 -> no halt until stall drops; then in HALT, start -> LOAD with pc=RESET_PC.
